// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB requester: FSM state encoding,
// PPROT bit positions and the slave-select width calculation.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int PROT_PRIV_BIT   = 0;
    localparam int PROT_NSEC_BIT   = 1;
    localparam int PROT_INSTR_BIT  = 2;

    // Number of upper address bits used to pick a completer.
    function automatic int sel_w(input int num_slaves);
        return (num_slaves > 1) ? $clog2(num_slaves) : 0;
    endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Command, response and APB bus bundle for the APB requester.
// master = the requester's view, slave = the command source / completer side.
interface apb_master_ctrl_if #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic                         cmd_write;
    logic [ADDR_W-1:0]            cmd_addr;
    logic [DATA_W-1:0]            cmd_wdata;
    logic [STRB_W-1:0]            cmd_strb;
    logic [2:0]                   cmd_prot;

    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    logic                         rsp_timeout;

    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [ADDR_W-1:0]            paddr;
    logic [DATA_W-1:0]            pwdata;
    logic [STRB_W-1:0]            pstrb;
    logic [2:0]                   pprot;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES-1:0]        pslverr;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, pslverr, prdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_slave_mux.sv
// Picks the ready/error/read-data of the currently addressed completer.
module apb_slave_mux #(
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int IDX_W      = 2
) (
    input  logic [IDX_W-1:0]             idx,
    input  logic [NUM_SLAVES-1:0]        pready,
    input  logic [NUM_SLAVES-1:0]        pslverr,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
    output logic                         sel_ready,
    output logic                         sel_err,
    output logic [DATA_W-1:0]            sel_rdata
);

    logic [DATA_W-1:0] slot_rdata [NUM_SLAVES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
            assign slot_rdata[gi] = prdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (32'(idx) == i) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                sel_rdata = slot_rdata[i];
            end
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 requester: accepts single-beat commands, runs SETUP/ACCESS on the
// decoded completer and returns a one-cycle registered response.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    apb_master_ctrl_if.master bus
);

    localparam int SEL_W  = sel_w(NUM_SLAVES);
    localparam int IDX_W  = (SEL_W > 0) ? SEL_W : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e              state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic                    dec_err_reg, dec_err_next;
    logic [NUM_SLAVES-1:0]   psel_reg, psel_next;
    logic                    penable_reg, penable_next;
    logic                    pwrite_reg, pwrite_next;
    logic [ADDR_W-1:0]       paddr_reg, paddr_next;
    logic [DATA_W-1:0]       pwdata_reg, pwdata_next;
    logic [STRB_W-1:0]       pstrb_reg, pstrb_next;
    logic [2:0]              pprot_reg, pprot_next;
    logic [CNT_W-1:0]        wait_cnt_reg, wait_cnt_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]       rsp_rdata_reg, rsp_rdata_next;
    logic                    rsp_err_reg, rsp_err_next;
    logic                    rsp_timeout_reg, rsp_timeout_next;

    logic [IDX_W-1:0]        cmd_idx;
    logic                    cmd_dec_err;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_W-1:0]       sel_rdata;

    generate
        if (SEL_W > 0) begin : g_dec
            assign cmd_idx = bus.cmd_addr[ADDR_W-1 -: SEL_W];
        end else begin : g_nodec
            assign cmd_idx = '0;
        end
    endgenerate

    assign cmd_dec_err = (32'(cmd_idx) >= NUM_SLAVES);

    apb_slave_mux #(
        .DATA_W     (DATA_W),
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W)
    ) u_mux (
        .idx       (idx_reg),
        .pready    (bus.pready),
        .pslverr   (bus.pslverr),
        .prdata    (bus.prdata),
        .sel_ready (sel_ready),
        .sel_err   (sel_err),
        .sel_rdata (sel_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            dec_err_reg     <= 1'b0;
            psel_reg        <= '0;
            penable_reg     <= 1'b0;
            pwrite_reg      <= 1'b0;
            paddr_reg       <= '0;
            pwdata_reg      <= '0;
            pstrb_reg       <= '0;
            pprot_reg       <= '0;
            wait_cnt_reg    <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            dec_err_reg     <= dec_err_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            pwrite_reg      <= pwrite_next;
            paddr_reg       <= paddr_next;
            pwdata_reg      <= pwdata_next;
            pstrb_reg       <= pstrb_next;
            pprot_reg       <= pprot_next;
            wait_cnt_reg    <= wait_cnt_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        dec_err_next     = dec_err_reg;
        psel_next        = psel_reg;
        penable_next     = penable_reg;
        pwrite_next      = pwrite_reg;
        paddr_next       = paddr_reg;
        pwdata_next      = pwdata_reg;
        pstrb_next       = pstrb_reg;
        pprot_next       = pprot_reg;
        wait_cnt_next    = wait_cnt_reg;
        rsp_valid_next   = 1'b0;
        rsp_rdata_next   = '0;
        rsp_err_next     = 1'b0;
        rsp_timeout_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    idx_next     = cmd_idx;
                    dec_err_next = cmd_dec_err;
                    state_next   = SETUP;
                    if (!cmd_dec_err) begin
                        psel_next   = NUM_SLAVES'(1) << cmd_idx;
                        pwrite_next = bus.cmd_write;
                        paddr_next  = bus.cmd_addr;
                        pprot_next  = bus.cmd_prot;
                        pwdata_next = bus.cmd_write ? bus.cmd_wdata : '0;
                        pstrb_next  = bus.cmd_write ? bus.cmd_strb : '0;
                    end
                end
            end
            SETUP: begin
                // A decode error spends this cycle with psel low, then reports.
                if (dec_err_reg) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                end else begin
                    state_next    = ACCESS;
                    penable_next  = 1'b1;
                    wait_cnt_next = '0;
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_next     = RESP;
                    psel_next      = '0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = sel_err;
                    rsp_rdata_next = (!pwrite_reg && !sel_err) ? sel_rdata : '0;
                end else if ((TIMEOUT != 0) && (wait_cnt_reg == CNT_W'(TIMEOUT - 1))) begin
                    // This is the TIMEOUT-th ACCESS cycle without pready.
                    state_next       = RESP;
                    psel_next        = '0;
                    penable_next     = 1'b0;
                    rsp_valid_next   = 1'b1;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready   = (state_reg == IDLE);
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign bus.rsp_err     = rsp_err_reg;
    assign bus.rsp_timeout = rsp_timeout_reg;
    assign bus.psel        = psel_reg;
    assign bus.penable     = penable_reg;
    assign bus.pwrite      = pwrite_reg;
    assign bus.paddr       = paddr_reg;
    assign bus.pwdata      = pwdata_reg;
    assign bus.pstrb       = pstrb_reg;
    assign bus.pprot       = pprot_reg;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed vector table, randomized transfers
// against a behavioural model, reset-abort and decode-error sequences.
module tb_apb_master_ctrl;
    import apb_pkg::*;

    localparam int NS_A = 4;
    localparam int NS_B = 3;
    localparam int TMO  = 16;

    typedef struct {
        bit          write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        bit          err;
        logic [31:0] rdata;
        int          exp_lat;
        bit          exp_err;
        bit          exp_to;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   txn_no = 0;

    // Completer model state for DUT A
    logic [1:0] cur_idx = 2'd0;
    int         wait_cfg = 0;
    bit         err_cfg = 1'b0;
    logic [3:0] noise_rdy = 4'h0;
    logic [3:0] noise_err = 4'h0;
    int         acc_cnt = 0;

    always #5 clk = ~clk;

    apb_master_ctrl_if #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(NS_A)) bus_a ();
    apb_master_ctrl_if #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(NS_B)) bus_b ();

    apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(NS_A), .TIMEOUT(TMO)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.master)
    );

    apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .NUM_SLAVES(NS_B), .TIMEOUT(TMO)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.master)
    );

    // Addressed completer answers after wait_cfg ACCESS cycles; others show noise.
    always_comb begin
        bus_a.pready           = noise_rdy;
        bus_a.pslverr          = noise_err;
        bus_a.pready[cur_idx]  = bus_a.penable && (acc_cnt == wait_cfg);
        bus_a.pslverr[cur_idx] = err_cfg;
    end

    always @(posedge clk) begin
        if (bus_a.penable && !bus_a.pready[cur_idx]) acc_cnt <= acc_cnt + 1;
        else                                          acc_cnt <= 0;
    end

    assign bus_b.pready  = '1;
    assign bus_b.pslverr = '0;
    assign bus_b.prdata  = {32'h33333333, 32'h22222222, 32'h11111111};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: outcome of one command from the address map and slave behaviour.
    function automatic vec_t fill_exp(input vec_t v);
        vec_t r = v;
        int   idx = int'(v.addr) / 64;
        if (idx >= NS_A) begin
            r.exp_lat = 2; r.exp_err = 1; r.exp_to = 0; r.exp_rdata = 0;
        end else if (TMO != 0 && v.waits >= TMO) begin
            r.exp_lat = 2 + TMO; r.exp_err = 1; r.exp_to = 1; r.exp_rdata = 0;
        end else begin
            r.exp_lat   = 3 + v.waits;
            r.exp_err   = v.err;
            r.exp_to    = 0;
            r.exp_rdata = (v.write || v.err) ? 32'h0 : v.rdata;
        end
        return r;
    endfunction

    // Called at a negedge while DUT A is idle; drives the command and slave setup.
    task automatic drive_a(input vec_t v);
        logic [127:0] rd;
        rd = {$urandom, $urandom, $urandom, $urandom};
        cur_idx   = v.addr[7:6];
        wait_cfg  = v.waits;
        err_cfg   = v.err;
        noise_rdy = 4'($urandom);
        noise_err = 4'($urandom);
        rd[32*int'(v.addr[7:6]) +: 32] = v.rdata;
        bus_a.prdata    = rd;
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_write = v.write;
        bus_a.cmd_addr  = v.addr;
        bus_a.cmd_wdata = v.wdata;
        bus_a.cmd_strb  = v.strb;
        bus_a.cmd_prot  = v.prot;
    endtask

    task automatic scramble_a();
        bus_a.cmd_valid = 1'b0;
        bus_a.cmd_write = 1'($urandom);
        bus_a.cmd_addr  = 8'($urandom);
        bus_a.cmd_wdata = $urandom;
        bus_a.cmd_strb  = 4'($urandom);
        bus_a.cmd_prot  = 3'($urandom);
    endtask

    task automatic run_a(input vec_t v);
        int         bad = 0;
        int         pen = 0;
        int         lat = v.exp_lat;
        logic [3:0] exp_psel = 4'(1 << int'(v.addr[7:6]));
        drive_a(v);
        check("cmd_ready_idle", bus_a.cmd_ready, 1);
        @(posedge clk);
        #1 scramble_a();
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (bus_a.penable) pen++;
            if (k < lat) begin
                if (bus_a.psel !== exp_psel || bus_a.penable !== (k >= 2) ||
                    bus_a.rsp_valid !== 1'b0 || bus_a.cmd_ready !== 1'b0 ||
                    bus_a.paddr !== v.addr || bus_a.pwrite !== v.write ||
                    bus_a.pwdata !== (v.write ? v.wdata : 32'h0) ||
                    bus_a.pstrb !== (v.write ? v.strb : 4'h0) || bus_a.pprot !== v.prot)
                    bad++;
            end else if (k == lat) begin
                check("rsp_valid", bus_a.rsp_valid, 1);
                check("rsp_err", bus_a.rsp_err, v.exp_err);
                check("rsp_timeout", bus_a.rsp_timeout, v.exp_to);
                check("rsp_rdata", bus_a.rsp_rdata, v.exp_rdata);
                if (bus_a.psel !== 4'h0 || bus_a.penable !== 1'b0 || bus_a.cmd_ready !== 1'b0) bad++;
            end else begin
                if (bus_a.rsp_valid !== 1'b0 || bus_a.rsp_err !== 1'b0 || bus_a.rsp_timeout !== 1'b0 ||
                    bus_a.rsp_rdata !== 32'h0 || bus_a.cmd_ready !== 1'b1 || bus_a.psel !== 4'h0)
                    bad++;
            end
        end
        check("bus_seq", 64'(bad), 0);
        check("penable_cycles", 64'(pen), 64'(lat - 2));
        $display("[TB] txn %0d %s addr=%02h waits=%0d lat=%0d err=%0b to=%0b rdata=%08h",
                 txn_no, v.write ? "WR" : "RD", v.addr, v.waits, lat, bus_a.rsp_err, v.exp_to, v.exp_rdata);
        txn_no++;
    endtask

    task automatic run_b(input logic [7:0] addr, input bit write, input int lat, input bit exp_err,
                         input logic [2:0] exp_psel, input logic [31:0] exp_rdata);
        int bad = 0;
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_write = write;
        bus_b.cmd_addr  = addr;
        bus_b.cmd_wdata = $urandom;
        bus_b.cmd_strb  = 4'hF;
        bus_b.cmd_prot  = 3'b000;
        check("b_cmd_ready", bus_b.cmd_ready, 1);
        @(posedge clk);
        #1 bus_b.cmd_valid = 1'b0;
        bus_b.cmd_addr = 8'($urandom);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k < lat) begin
                if (bus_b.psel !== exp_psel || bus_b.rsp_valid !== 1'b0 ||
                    bus_b.penable !== (exp_psel != 3'b000 && k >= 2))
                    bad++;
            end else if (k == lat) begin
                check("b_rsp_valid", bus_b.rsp_valid, 1);
                check("b_rsp_err", bus_b.rsp_err, exp_err);
                check("b_rsp_timeout", bus_b.rsp_timeout, 0);
                check("b_rsp_rdata", bus_b.rsp_rdata, exp_rdata);
                if (bus_b.psel !== 3'b000) bad++;
            end else begin
                if (bus_b.rsp_valid !== 1'b0 || bus_b.cmd_ready !== 1'b1 || bus_b.psel !== 3'b000) bad++;
            end
        end
        check("b_bus_seq", 64'(bad), 0);
        $display("[TB] txn %0d B %s addr=%02h lat=%0d err=%0b rdata=%08h",
                 txn_no, write ? "WR" : "RD", addr, lat, exp_err, exp_rdata);
        txn_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t r;
        int   rsp_seen;
        logic [2:0] prot_ns;

        prot_ns = 3'(1 << PROT_NSEC_BIT);
        //          wr  addr   wdata         strb  prot     waits err rdata         lat err to rdata
        vecs[0] = '{1, 8'h41, 32'hDEADBEEF, 4'hF, prot_ns, 0,   0, 32'h0,        3,  0,  0, 32'h0};
        vecs[1] = '{0, 8'hC4, 32'h0,        4'h0, 3'b000,  3,   0, 32'h12345678, 6,  0,  0, 32'h12345678};
        vecs[2] = '{0, 8'h80, 32'h0,        4'h0, 3'b001,  1,   1, 32'hAAAA5555, 4,  1,  0, 32'h0};
        vecs[3] = '{0, 8'h00, 32'h0,        4'h0, 3'b100,  100, 0, 32'h55555555, 18, 1,  1, 32'h0};
        vecs[4] = '{0, 8'h04, 32'h0,        4'h0, 3'b011,  15,  0, 32'h0BADF00D, 18, 0,  0, 32'h0BADF00D};
        vecs[5] = '{1, 8'h7C, 32'hCAFE0001, 4'h5, 3'b111,  2,   1, 32'h0,        5,  1,  0, 32'h0};
        vecs[6] = '{1, 8'hE0, 32'h01020304, 4'hA, 3'b010,  16,  0, 32'h0,        18, 1,  1, 32'h0};

        reset = 1'b1;
        bus_a.cmd_valid = 1'b0; bus_a.cmd_write = 1'b0; bus_a.cmd_addr = '0;
        bus_a.cmd_wdata = '0;   bus_a.cmd_strb = '0;    bus_a.cmd_prot = '0;
        bus_a.prdata = '0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_write = 1'b0; bus_b.cmd_addr = '0;
        bus_b.cmd_wdata = '0;   bus_b.cmd_strb = '0;    bus_b.cmd_prot = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus_a.cmd_ready, 1);
        check("rst_psel", bus_a.psel, 0);
        check("rst_penable", bus_a.penable, 0);
        check("rst_rsp_valid", bus_a.rsp_valid, 0);
        check("rst_rsp_fields", {bus_a.rsp_err, bus_a.rsp_timeout, bus_a.rsp_rdata}, 0);
        check("rst_bus_fields", {bus_a.paddr, bus_a.pwdata, bus_a.pstrb, bus_a.pprot, bus_a.pwrite}, 0);
        check("rst_b_cmd_ready", bus_b.cmd_ready, 1);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_a(vecs[i]);

        // Reset while a read to slave 2 is stuck in ACCESS.
        r = fill_exp('{0, 8'h88, 32'h0, 4'h0, 3'b000, 50, 0, 32'h76543210, 0, 0, 0, 32'h0});
        drive_a(r);
        @(posedge clk);
        #1 scramble_a();
        repeat (4) @(negedge clk);
        check("pre_rst_penable", bus_a.penable, 1);
        check("pre_rst_psel", bus_a.psel, 4'b0100);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_psel", bus_a.psel, 0);
        check("mid_rst_penable", bus_a.penable, 0);
        check("mid_rst_cmd_ready", bus_a.cmd_ready, 1);
        check("mid_rst_rsp_valid", bus_a.rsp_valid, 0);
        reset = 1'b0;
        rsp_seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus_a.rsp_valid) rsp_seen++;
        end
        check("post_rst_no_rsp", 64'(rsp_seen), 0);
        run_a(fill_exp('{1, 8'h90, 32'h600DF00D, 4'h3, 3'b001, 1, 0, 32'h0, 0, 0, 0, 32'h0}));

        for (int n = 0; n < 40; n++) begin
            r.write = 1'($urandom_range(0, 1));
            r.addr  = 8'($urandom);
            r.wdata = $urandom;
            r.strb  = 4'($urandom);
            r.prot  = 3'($urandom);
            r.waits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 3));
            r.err   = ($urandom_range(0, 3) == 0);
            r.rdata = $urandom;
            run_a(fill_exp(r));
        end

        run_b(8'hC0, 1'b0, 2, 1'b1, 3'b000, 32'h0);
        run_b(8'h80, 1'b0, 3, 1'b0, 3'b100, 32'h33333333);
        run_b(8'hFF, 1'b1, 2, 1'b1, 3'b000, 32'h0);
        run_b(8'h40, 1'b1, 3, 1'b0, 3'b010, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Synthesisable, parametrised APB4 requester that replaces task-driven bus stimulus with RTL.
- Accepts single-beat commands on a valid/ready interface and runs a SETUP/ACCESS APB transfer to one of NUM_SLAVES completers, selected by address decode.
- Returns read data and error status on a registered response interface.
- Adds features absent from the existing single-slave flow: PSTRB, wait-state timeout, decode error, multi-slave select.

Parameters:
- ADDR_W, 8, address width; the top SEL_W bits select the slave.
- DATA_W, 32, data width; multiple of 8.
- NUM_SLAVES, 4, number of completers; range 1..16. SEL_W = (NUM_SLAVES>1) ? $clog2(NUM_SLAVES) : 0.
- TIMEOUT, 16, maximum ACCESS cycles without pready; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr, decode error, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  NUM_SLAVES  one-hot slave select.
- penable  out  1  ACCESS phase.
- pwrite  out  1  transfer direction.
- paddr  out  ADDR_W  transfer address.
- pwdata  out  DATA_W  write data.
- pstrb  out  DATA_W/8  write strobes.
- pprot  out  3  protection.
- pready  in  NUM_SLAVES  per-slave ready.
- pslverr  in  NUM_SLAVES  per-slave error.
- prdata  in  NUM_SLAVES*DATA_W  flattened; slave i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 except cmd_ready, which is 1.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, register write/addr/wdata/strb/prot and decode the slave index idx = cmd_addr[ADDR_W-1 -: SEL_W] (idx=0 if SEL_W=0).
  - If idx >= NUM_SLAVES: decode error. Go to RESP with rsp_err=1; no bus activity.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - psel[idx]=1, penable=0; paddr/pwrite/pprot driven.
  - pwdata/pstrb = registered values on writes, 0 on reads.
  - Go to ACCESS.
- ACCESS:
  - psel[idx]=1, penable=1; all bus signals held stable.
  - Only pready[idx], pslverr[idx] and prdata slice idx are observed.
  - On pready[idx]=1: capture pslverr[idx] and (reads only) prdata[idx]; go to RESP.
  - Wait counter counts ACCESS cycles with pready low. When TIMEOUT!=0 and the count reaches TIMEOUT: abort, drive psel/penable low next cycle, set rsp_err=1 and rsp_timeout=1, go to RESP.
  - pready arriving in the same cycle the count reaches TIMEOUT: pready wins, no timeout.
- RESP (1 cycle):
  - rsp_valid=1 with registered rsp_* fields; psel=0, penable=0; go to IDLE.
  - rsp_* fields return to 0 when rsp_valid deasserts.
- Latency: zero-wait transfer accepted at cycle N gives SETUP N+1, ACCESS N+2, rsp_valid N+3, next accept N+4. Each pready wait state adds 1 cycle.
- cmd_ready=0 in every state except IDLE; there is no response backpressure.
- rsp_rdata is 0 on writes, on pslverr, and on timeout.
- Reset asserted mid-transfer: next edge goes to IDLE, psel/penable drop immediately, no response is issued.
- Bus outputs are registered; no combinational path from the cmd_* inputs to the APB outputs.

Decomposition:
- Package apb_pkg: state enum apb_state_e (IDLE, SETUP, ACCESS, RESP), PROT bit-position constants, and a function computing SEL_W.
- One sub-module, apb_slave_mux: combinational select of pready/pslverr/prdata by registered idx.
- apb_master_ctrl holds the FSM, the command registers and the timeout counter.

Test Plan:
- Write 0xDEADBEEF, addr 0x41, strb 0xF, prot 3'b010, slave 1 zero-wait: psel=4'b0010; penable rises 1 cycle after psel; rsp_valid at N+3; rsp_err=0; rsp_rdata=0.
- Read addr 0xC4, slave 3 returns 0x12345678 after 3 wait states: rsp_valid at N+6; rsp_rdata=0x12345678; pstrb=0 throughout.
- Read with pslverr[2]=1 at pready: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- NUM_SLAVES=3, addr 0xC0: no psel bit ever set; rsp_valid at N+2 with rsp_err=1.
- Slave 0 holds pready=0, TIMEOUT=16: penable high exactly 16 cycles, then psel/penable drop; rsp_err=1, rsp_timeout=1. Repeat with pready arriving on cycle 16: normal completion.
- Reset asserted during ACCESS: psel=0, penable=0, cmd_ready=1 next cycle; no rsp_valid. A following write completes normally.
